// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1 serial receiver feeding the ACIA RX
// data register and status bits. Each bit is decided by a 3-sample majority
// vote around its centre; a low stop bit reports a framing error and the
// receiver then waits out any break condition before hunting for a new start.

module uart_rx_os #(
    parameter int SCW     = 11,
    parameter int sym_cnt = 1667
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err,
    output logic       rx_busy
);

    // One oversample tick every sym_cnt/16 enabled cycles (truncated).
    localparam int             TICK_LEN = sym_cnt >> 4;
    localparam logic [SCW-1:0] TICK_MAX = SCW'(TICK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t         state;
    logic [1:0]     sync;
    logic [SCW-1:0] tick_cnt;
    logic [3:0]     tcnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           samp7;
    logic           samp8;

    logic rx_s;
    logic tick;
    logic sample_pt;
    logic vote_pt;
    logic vote;

    // Decode the tick wrap, the first cycle of each tcnt value, and the
    // majority of the samples taken at tcnt 7, 8 and 9 of the current bit.
    always_comb begin
        rx_s      = sync[1];
        tick      = (tick_cnt == TICK_MAX);
        sample_pt = (tick_cnt == '0);
        vote_pt   = sample_pt && (tcnt == 4'd9);
        vote      = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    end

    // Synchronizer, oversample counters, frame state machine and registered
    // outputs; everything freezes when pclk is low so the strobe stretches
    // across disabled cycles and is seen exactly once by an enabled consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sync      <= 2'b11;
            tick_cnt  <= '0;
            tcnt      <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            rx_dat    <= 8'h00;
            rx_stb    <= 1'b0;
            rx_err    <= 1'b0;
            rx_busy   <= 1'b0;
        end else if (pclk) begin
            sync   <= {sync[0], rx_serial};
            rx_stb <= 1'b0;

            if (state == S_IDLE) begin
                tick_cnt <= '0;
                tcnt     <= 4'd0;
            end else if (tick) begin
                tick_cnt <= '0;
                tcnt     <= tcnt + 4'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (sample_pt && (tcnt == 4'd7)) begin
                samp7 <= rx_s;
            end
            if (sample_pt && (tcnt == 4'd8)) begin
                samp8 <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (vote_pt) begin
                        if (!vote) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (vote_pt) begin
                        shift_reg <= {vote, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (vote_pt) begin
                        rx_dat <= shift_reg;
                        rx_stb <= 1'b1;
                        rx_err <= ~vote;
                        if (vote) begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    if (rx_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling asynchronous serial receiver (8N1, LSB first) that converts the raw `rx` pin into parallel bytes for the ACIA register block. It sits directly upstream of the ACIA status/data logic and drives the byte, strobe and error signals that the ACIA latches into its RX data register and status bits. It provides start-bit validation, 3-sample majority voting per bit, framing-error detection and break handling.

## Interface

Parameters:

- `SCW`, 11, width of the oversample tick counter; must hold `sym_cnt/16 - 1`.
- `sym_cnt`, 1667, bit period in enabled clock cycles (16 MHz / 9600 baud).
- Tick period is `sym_cnt >> 4` enabled cycles, default 104. The truncation error of 0.2 % is accepted.

Ports:

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset; it has priority over `pclk`.
- `pclk`  in  1  peripheral clock enable; all state advances only in `clk` cycles where `pclk`=1.
- `rx_serial`  in  1  raw asynchronous serial input; idle level is high.
- `rx_dat`  out  8  last received byte.
- `rx_stb`  out  1  frame-complete strobe.
- `rx_err`  out  1  framing error of the last completed frame.
- `rx_busy`  out  1  high while a frame is in progress.

## Operation

- **Synchronizer:** two flops sample `rx_serial`, advancing on `pclk` only. Both flops reset to 1 so that reset release cannot create a false start.
- **Tick generator:** counts 0 to `(sym_cnt>>4)-1` and emits one tick on wrap. It is cleared on entry to START. `tcnt` is a 4-bit tick-within-bit counter.
- **Majority vote:** the voted bit value is the majority of the synchronized samples taken at `tcnt` = 7, 8 and 9. The vote is evaluated at `tcnt`=9.

State machine:

- **IDLE:** `rx_busy`=0. When the synchronized input is 0, go to START and clear the tick and `tcnt` counters.
- **START:** at `tcnt`=9, a vote of 0 goes to DATA with bit index 0. A vote of 1 is a false start: go to IDLE with no strobe.
- **DATA:** the vote at `tcnt`=9 of each bit is shifted into the MSB of the shift register, so the byte is received LSB first. Bit boundaries fall on `tcnt` wrap 15→0. After bit 7's vote, go to STOP.
- **STOP:** at `tcnt`=9:
  - Vote 1: load `rx_dat`, clear `rx_err`, pulse `rx_stb`, go to IDLE. Returning at mid-stop allows early resync on the next start edge.
  - Vote 0: load `rx_dat`, set `rx_err`, pulse `rx_stb`, go to BREAK.
- **BREAK:** wait until the synchronized input is 1, then go to IDLE. While in BREAK there is no start detection and no strobe.

Outputs:

- `rx_busy` is 1 in START, DATA, STOP and BREAK.
- `rx_err` is a level. It changes only when a frame completes.
- `rx_dat` holds its value until the next completed frame.

## Timing

- **Reset values:** `rx_dat`=8'h00, `rx_stb`=0, `rx_err`=0, `rx_busy`=0, state IDLE, synchronizer=2'b11, all counters 0.
- **Reset mid-frame:** aborts the frame. There is no strobe and the outputs return to their reset values on the next `clk` edge.
- **Registered outputs:** all outputs update only in cycles with `pclk`=1.
- **`rx_stb` width:** high for exactly one `pclk`-enabled cycle and held through any intervening `pclk`=0 cycles. A consumer sampling on `pclk` therefore sees it exactly once.
- **Start latency:** START is entered 2 enabled cycles after the falling edge reaches `rx_serial` (synchronizer delay).
- **Strobe latency:** `rx_stb` rises one enabled cycle after the tick that produces `tcnt`=9 of the stop bit. That is about 9.5 bit periods after the start edge, plus 2 cycles.
- **Data timing:** `rx_dat` and `rx_err` are valid in the same cycle that `rx_stb` is first high.
- **Back-to-back frames:** a start edge arriving after STOP's vote is accepted with no gap cycles required.
- **Frozen state:** `pclk`=0 freezes all state, including the synchronizer and counters.

## Test plan

All scenarios use `sym_cnt`=32 (tick period 2). A bit period is 32 enabled cycles.

1. **Reset:** assert `reset` for 3 cycles with `rx_serial`=1 → `rx_dat`=00, `rx_stb`=0, `rx_err`=0, `rx_busy`=0.
2. **Basic frame:** drive 0x55 8N1 with `pclk`=1 → exactly one `rx_stb`, `rx_dat`=0x55, `rx_err`=0, strobe about 304 cycles after the start edge. `rx_busy` falls with the strobe.
3. **False start and glitch rejection:**
   - Low glitch on `rx_serial` lasting 3 cycles while idle → returns to IDLE, no `rx_stb`.
   - Frame 0x00 with a 1-cycle high glitch at the centre of bit 2 → `rx_dat`=0x00.
4. **Framing error and break:** frame 0xA3 with stop bit 0, then line held low for 3 bit periods → one `rx_stb` with `rx_dat`=0xA3 and `rx_err`=1, and no further strobes. After the line returns high, frame 0x3C → `rx_dat`=0x3C, `rx_err`=0.
5. **Reset mid-frame:** assert `reset` during data bit 4 of 0xFF → no `rx_stb`, outputs at reset values. The following frame 0x7E is received correctly.
6. **Enable gating:** `pclk` asserted 1 cycle in 2, with frames 0x01 and 0xFF sent back-to-back at the enabled-cycle rate → two strobes, each exactly one enabled cycle wide, with `rx_dat` = 0x01 then 0xFF and `rx_err`=0.
